// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad. One column is driven low at a time.
//   The rows are synchronised and then sampled on the last cycle of each
//   column dwell. Presses and releases are debounced. The accepted key is
//   presented as a stable one-hot active-low column/row pair. The block also
//   outputs a binary key code and gives a single-cycle pulse for each press.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-low reset
//   row_n      keypad rows, active-low, asynchronous to clk
//   col_n      keypad column drive, one-hot active-low
//   key_c      debounced column, one-hot active-low, 4'hF = no key
//   key_r      debounced row, one-hot active-low, 4'hF = no key
//   key_code   col*4 + row of the accepted key
//   key_valid  one-cycle pulse when a press is accepted
//   key_held   high while an accepted key is held (through release debounce)
module keypad_scanner #(
  parameter int SCAN_DIV = 16,  // clk cycles per column dwell (>=3)
  parameter int DEBOUNCE = 4    // consecutive matching samples to accept (>=1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_c,
  output logic [3:0] key_r,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = $clog2(DEBOUNCE + 1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_TARGET = DEB_W'(DEBOUNCE);
  localparam logic [DEB_W-1:0] DEB_ONE    = DEB_W'(1);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } state_t;

  // Registered state
  logic [3:0]       row_meta, row_sync;
  logic [DIV_W-1:0] div_cnt;
  state_t           state;
  logic [1:0]       col_idx;
  logic [1:0]       cap_row;
  logic [DEB_W-1:0] deb_cnt;

  // Next-state values
  state_t           state_nx;
  logic [1:0]       col_nx;
  logic [1:0]       cap_nx;
  logic [DEB_W-1:0] deb_nx;
  logic [3:0]       key_c_nx, key_r_nx, code_nx;
  logic             valid_nx, held_nx;

  logic       sample;
  logic       any_low;
  logic       cap_low;
  logic [1:0] win_row;
  logic [DEB_W-1:0] deb_inc;
  logic       load_key;
  logic       drop_key;

  assign col_n   = ~(4'b0001 << col_idx);
  assign sample  = (div_cnt == DIV_LAST);
  assign any_low = (row_sync != 4'hF);
  assign cap_low = ~row_sync[cap_row];
  assign deb_inc = deb_cnt + DEB_ONE;

  // When several rows read low, the lowest row index wins.
  always_comb begin
    win_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_sync[i]) win_row = 2'(i);
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first. With defaults,
    // a branch that does not assign a signal cannot create a latch.
    state_nx = state;
    col_nx   = col_idx;
    cap_nx   = cap_row;
    deb_nx   = deb_cnt;
    key_c_nx = key_c;
    key_r_nx = key_r;
    code_nx  = key_code;
    valid_nx = 1'b0;
    held_nx  = key_held;
    load_key = 1'b0;
    drop_key = 1'b0;

    if (sample) begin
      unique case (state)
        ST_SCAN: begin
          if (!any_low) begin
            col_nx = col_idx + 2'd1;
          end else begin
            cap_nx = win_row;
            deb_nx = DEB_ONE;
            if (DEB_ONE >= DEB_TARGET) load_key = 1'b1;
            else                       state_nx = ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (cap_low) begin
            deb_nx = deb_inc;
            if (deb_inc >= DEB_TARGET) load_key = 1'b1;
          end else begin
            state_nx = ST_SCAN;
            col_nx   = col_idx + 2'd1;
            deb_nx   = '0;
          end
        end
        ST_HELD: begin
          // Only the captured row matters here. A second key is ignored.
          if (!cap_low) begin
            deb_nx = DEB_ONE;
            if (DEB_ONE >= DEB_TARGET) drop_key = 1'b1;
            else                       state_nx = ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!cap_low) begin
            deb_nx = deb_inc;
            if (deb_inc >= DEB_TARGET) drop_key = 1'b1;
          end else begin
            // The key bounced back down. Resume holding without a new pulse.
            state_nx = ST_HELD;
            deb_nx   = '0;
          end
        end
        default: state_nx = ST_SCAN;
      endcase
    end

    if (load_key) begin
      state_nx = ST_HELD;
      deb_nx   = '0;
      valid_nx = 1'b1;
      held_nx  = 1'b1;
      key_c_nx = ~(4'b0001 << col_idx);
      key_r_nx = ~(4'b0001 << cap_nx);
      code_nx  = {col_idx, cap_nx};
    end

    if (drop_key) begin
      state_nx = ST_SCAN;
      deb_nx   = '0;
      held_nx  = 1'b0;
      key_c_nx = 4'hF;
      key_r_nx = 4'hF;
      col_nx   = col_idx + 2'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. Every flop
  // then updates from the values it had before the clock edge, so the
  // two-flop synchroniser works as a real two-stage chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_meta  <= 4'hF;
      row_sync  <= 4'hF;
      div_cnt   <= '0;
      state     <= ST_SCAN;
      col_idx   <= 2'd0;
      cap_row   <= 2'd0;
      deb_cnt   <= '0;
      key_c     <= 4'hF;
      key_r     <= 4'hF;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      row_meta  <= row_n;
      row_sync  <= row_meta;
      div_cnt   <= sample ? '0 : div_cnt + 1'b1;
      state     <= state_nx;
      col_idx   <= col_nx;
      cap_row   <= cap_nx;
      deb_cnt   <= deb_nx;
      key_c     <= key_c_nx;
      key_r     <= key_r_nx;
      key_code  <= code_nx;
      key_valid <= valid_nx;
      key_held  <= held_nx;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Directed testbench for keypad_scanner with the default parameters
//   (SCAN_DIV=16, DEBOUNCE=4). A keypad model pulls row r low while column c
//   is driven low, for every key (c,r) that is marked as pressed.
module tb_keypad_scanner;

  logic       clk;
  logic       rst_n;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_c;
  logic [3:0] key_r;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [3:0][3:0] pressed;  // pressed[col][row]
  int cyc;
  int pulses;
  int errors;
  int checks;

  keypad_scanner dut (
    .clk      (clk),
    .reset    (rst_n),
    .row_n    (row_n),
    .col_n    (col_n),
    .key_c    (key_c),
    .key_r    (key_r),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    row_n = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (pressed[c][r] && !col_n[c]) row_n[r] = 1'b0;
  end

  // Count of clock edges since reset release. Column samples fall on the
  // edges where cyc becomes a multiple of 16.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(posedge clk) begin
    if (key_valid === 1'b1) pulses <= pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Moves to 4 cycles after a column sample, so that the next stimulus
  // change settles well before the following sample.
  task automatic align();
    int n = 0;
    do begin
      tick();
      n++;
    end while ((cyc % 16) != 4 && n < 64);
    if (n >= 64) check("align_timeout", 32'(n), 32'(0));
  endtask

  task automatic step(input int samples);
    repeat (16 * samples) @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int target);
    int n = 0;
    while (cyc != target && n < 5000) begin
      tick();
      n++;
    end
    if (n >= 5000) check("wait_cyc_timeout", 32'(cyc), 32'(target));
  endtask

  // The key is on column 0 from reset release. It is detected at edge 16
  // and accepted 3 samples later, at edge 64.
  task automatic press_latency(input string tag, input int exp_pulses);
    wait_cyc(63);
    check({tag, "_no_early_pulse"}, 32'(key_valid), 32'(0));
    check({tag, "_not_held_early"}, 32'(key_held), 32'(0));
    tick();
    check({tag, "_pulse"}, 32'(key_valid), 32'(1));
    check({tag, "_code"}, 32'(key_code), 32'(0));
    check({tag, "_key_c"}, 32'(key_c), 32'(4'b1110));
    check({tag, "_key_r"}, 32'(key_r), 32'(4'b1110));
    check({tag, "_held"}, 32'(key_held), 32'(1));
    tick();
    check({tag, "_pulse_one_cycle"}, 32'(key_valid), 32'(0));
    check({tag, "_pulse_count"}, 32'(pulses), 32'(exp_pulses));
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    pulses  = 0;
    pressed = '0;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_col_n", 32'(col_n), 32'(4'b1110));
    check("rst_key_c", 32'(key_c), 32'(4'hF));
    check("rst_key_r", 32'(key_r), 32'(4'hF));
    check("rst_key_code", 32'(key_code), 32'(0));
    check("rst_key_valid", 32'(key_valid), 32'(0));
    check("rst_key_held", 32'(key_held), 32'(0));
    rst_n = 1'b1;

    // 1. Press (c0,r0) and hold it for 2000 cycles.
    align();
    pressed[0][0] = 1'b1;
    press_latency("t1", 1);
    repeat (2000) @(posedge clk);
    align();
    check("t1_single_pulse", 32'(pulses), 32'(1));
    check("t1_col_frozen", 32'(col_n), 32'(4'b1110));
    check("t1_still_held", 32'(key_held), 32'(1));
    check("t1_key_c_stable", 32'(key_c), 32'(4'b1110));

    // 5. Release bounce: high for 2 samples, low for 1, then high for 4.
    pressed[0][0] = 1'b0;
    step(2);
    check("t5_held_after_2_high", 32'(key_held), 32'(1));
    pressed[0][0] = 1'b1;
    step(1);
    check("t5_held_after_bounce", 32'(key_held), 32'(1));
    pressed[0][0] = 1'b0;
    step(3);
    check("t5_held_after_3_high", 32'(key_held), 32'(1));
    check("t5_key_r_stable", 32'(key_r), 32'(4'b1110));
    step(1);
    check("t5_released", 32'(key_held), 32'(0));
    check("t5_key_c_clear", 32'(key_c), 32'(4'hF));
    check("t5_col_advance", 32'(col_n), 32'(4'b1101));
    check("t5_no_second_pulse", 32'(pulses), 32'(1));

    // 2. Press (c1,r0). Column 1 is the column being scanned now.
    pressed[1][0] = 1'b1;
    step(4);
    check("t2_pulse_count", 32'(pulses), 32'(2));
    check("t2_code", 32'(key_code), 32'(4));
    check("t2_key_c", 32'(key_c), 32'(4'b1101));
    check("t2_key_r", 32'(key_r), 32'(4'b1110));
    pressed[1][0] = 1'b0;
    step(4);
    check("t2_key_c_clear", 32'(key_c), 32'(4'hF));
    check("t2_key_r_clear", 32'(key_r), 32'(4'hF));
    check("t2_released", 32'(key_held), 32'(0));
    check("t2_col_n", 32'(col_n), 32'(4'b1011));
    check("t2_code_kept", 32'(key_code), 32'(4));

    // 3. Short press of (c2,r2) for 2 samples only.
    pressed[2][2] = 1'b1;
    step(2);
    check("t3_col_frozen", 32'(col_n), 32'(4'b1011));
    pressed[2][2] = 1'b0;
    step(1);
    check("t3_back_to_scan", 32'(col_n), 32'(4'b0111));
    step(1);
    check("t3_col_wrap", 32'(col_n), 32'(4'b1110));
    check("t3_no_pulse", 32'(pulses), 32'(2));
    check("t3_not_held", 32'(key_held), 32'(0));

    // 4. Press (c0,r1) and (c0,r2) together. The lower row wins.
    pressed[0][1] = 1'b1;
    pressed[0][2] = 1'b1;
    step(4);
    check("t4_pulse_count", 32'(pulses), 32'(3));
    check("t4_code", 32'(key_code), 32'(1));
    check("t4_key_r", 32'(key_r), 32'(4'b1101));
    check("t4_key_c", 32'(key_c), 32'(4'b1110));
    pressed[0][1] = 1'b0;
    pressed[0][2] = 1'b0;
    step(4);
    check("t4_released", 32'(key_held), 32'(0));
    check("t4_col_n", 32'(col_n), 32'(4'b1101));

    // 6. Reset while HELD on (c0,r0). The key stays pressed afterwards.
    pressed[0][0] = 1'b1;
    step(8);
    check("t6_held", 32'(key_held), 32'(1));
    check("t6_pulse_count", 32'(pulses), 32'(4));
    rst_n = 1'b0;
    #1;
    check("t6_rst_col_n", 32'(col_n), 32'(4'b1110));
    check("t6_rst_key_c", 32'(key_c), 32'(4'hF));
    check("t6_rst_key_r", 32'(key_r), 32'(4'hF));
    check("t6_rst_code", 32'(key_code), 32'(0));
    check("t6_rst_held", 32'(key_held), 32'(0));
    check("t6_rst_valid", 32'(key_valid), 32'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("t6_no_pulse_on_reset", 32'(pulses), 32'(4));
    press_latency("t6", 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
